// File: rtl/aes_io_pkg.sv
// Shared definitions for the matrix<->byte serialiser/deserialiser pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_io_pkg;

    // Default frame size in 32-bit words and bytes per word.
    localparam int WORDS_NUM_DEF  = 4;
    localparam int BYTES_PER_WORD = 4;

    // Transmit/receive FSM encoding; the receiver relies on the same values.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } io_state_e;

    // Number of bytes in a frame of the given word count.
    function automatic int frame_bytes(input int words);
        return words * BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/matrix_to_byte.sv
// Serialises a frame of 32-bit words into bytes, in0[31:24] first, in3[7:0] last.
// Latency: first byte valid the cycle after the load handshake; one idle bubble between frames.
// Backpressure: byte_ready low holds byte_out/byte_last/counter; load_ready low for the whole frame.
module matrix_to_byte
    import aes_io_pkg::*;
#(
    parameter int WORDS_NUM = WORDS_NUM_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last
);

    localparam int FRAME_BYTES = frame_bytes(WORDS_NUM);
    localparam int FRAME_W     = FRAME_BYTES * 8;
    localparam int CNT_W       = $clog2(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);

    io_state_e          state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [FRAME_W-1:0] load_frame;

    // The four input words always occupy the top of the frame, so the first
    // byte out is in0[31:24] regardless of the configured frame length.
    generate
        if (FRAME_W == 128) begin : g_frame_exact
            assign load_frame = {in0, in1, in2, in3};
        end else if (FRAME_W > 128) begin : g_frame_pad
            assign load_frame = {in0, in1, in2, in3, {(FRAME_W-128){1'b0}}};
        end else begin : g_frame_trunc
            logic [127:0] words_all;
            assign words_all  = {in0, in1, in2, in3};
            assign load_frame = words_all[127 -: FRAME_W];
        end
    endgenerate

    // Outputs come straight from registered state: no input-to-output paths.
    assign load_ready = (state_q == IDLE);
    assign byte_valid = (state_q == SEND);
    assign byte_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
    assign byte_out   = shift_q[FRAME_W-1 -: 8];

    // Next-state: load on the idle handshake, shift out one byte per sink handshake.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // byte_ready is deliberately not looked at while idle.
                if (load_valid) begin
                    shift_d = load_frame;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // load_valid is ignored here; the frame in flight is never replaced.
                if (byte_ready) begin
                    // Zero fill leaves byte_out at 0x00 once the frame has drained.
                    shift_d = {shift_q[FRAME_W-9:0], 8'h00};
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over any handshake and drops a partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
